// File: rtl/mips_pkg.sv
// Shared MIPS R-type constants: opcode/funct encodings, instruction field positions
// and a classifier used by the decode stage and the ALU.
package mips_pkg;

    localparam logic [5:0] OPCODE_RTYPE = 6'h00;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_SRA = 6'h03;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_XOR = 6'h26;
    localparam logic [5:0] FUNCT_NOR = 6'h27;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    typedef enum logic [1:0] {
        OP_ILLEGAL = 2'd0,
        OP_ARITH   = 2'd1,
        OP_SHIFT   = 2'd2
    } op_class_e;

    function automatic op_class_e classify(input logic [5:0] opcode, input logic [5:0] funct);
        op_class_e cls;
        cls = OP_ILLEGAL;
        if (opcode == OPCODE_RTYPE) begin
            case (funct)
                FUNCT_SLL, FUNCT_SRL, FUNCT_SRA: cls = OP_SHIFT;
                FUNCT_ADD, FUNCT_SUB, FUNCT_AND,
                FUNCT_OR,  FUNCT_XOR, FUNCT_NOR: cls = OP_ARITH;
                default:                         cls = OP_ILLEGAL;
            endcase
        end else begin
            cls = OP_ILLEGAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/regfile_r0.sv
// Architectural register file: two async read ports, one sync write port,
// r0 reads as zero, and write-to-read bypass on both ports.
module regfile_r0 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr0,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    output logic [DATA_WIDTH-1:0] rd_data0,
    output logic [DATA_WIDTH-1:0] rd_data1
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [NUM_REGS];
    logic                  wr_live_s;

    assign wr_live_s = wr_en && (wr_addr != {ADDR_WIDTH{1'b0}});

    // Register array storage; index 0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wr_live_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port 0 with r0 forcing and same-cycle bypass.
    always_comb begin
        rd_data0 = {DATA_WIDTH{1'b0}};
        if (rd_addr0 == {ADDR_WIDTH{1'b0}}) begin
            rd_data0 = {DATA_WIDTH{1'b0}};
        end else if (wr_live_s && (wr_addr == rd_addr0)) begin
            rd_data0 = wr_data;
        end else begin
            rd_data0 = mem_r[rd_addr0];
        end
    end

    // Read port 1 with r0 forcing and same-cycle bypass.
    always_comb begin
        rd_data1 = {DATA_WIDTH{1'b0}};
        if (rd_addr1 == {ADDR_WIDTH{1'b0}}) begin
            rd_data1 = {DATA_WIDTH{1'b0}};
        end else if (wr_live_s && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
        end else begin
            rd_data1 = mem_r[rd_addr1];
        end
    end

endmodule

// File: rtl/id_stage_r0.sv
// R-type decode and operand fetch feeding alu_r0 through a single-entry
// valid/ready output register; held operands track late writebacks.
module id_stage_r0
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int CTRL_WIDTH     = 6,
    parameter int SHAMT_WIDTH    = 5,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int INSTR_WIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        instrValid,
    input  logic [INSTR_WIDTH-1:0]      instr,
    output logic                        instrReady,
    input  logic                        wbEn,
    input  logic [REG_ADDR_WIDTH-1:0]   wbAddr,
    input  logic [DATA_WIDTH-1:0]       wbData,
    output logic                        outValid,
    input  logic                        outReady,
    output logic [2*DATA_WIDTH-1:0]     dataOut,
    output logic [CTRL_WIDTH-1:0]       ctrl,
    output logic [SHAMT_WIDTH-1:0]      shamt,
    output logic [REG_ADDR_WIDTH-1:0]   destAddr,
    output logic                        illegal
);

    logic [5:0]                opcode_s;
    logic [CTRL_WIDTH-1:0]     funct_s;
    logic [REG_ADDR_WIDTH-1:0] rs_s;
    logic [REG_ADDR_WIDTH-1:0] rt_s;
    logic [REG_ADDR_WIDTH-1:0] rd_s;
    logic [SHAMT_WIDTH-1:0]    shamt_field_s;
    op_class_e                 class_s;

    logic [REG_ADDR_WIDTH-1:0] src0_s;
    logic [REG_ADDR_WIDTH-1:0] src1_s;
    logic [SHAMT_WIDTH-1:0]    shamt_next_s;
    logic [REG_ADDR_WIDTH-1:0] dest_next_s;
    logic                      illegal_next_s;
    logic [DATA_WIDTH-1:0]     rd_data0_s;
    logic [DATA_WIDTH-1:0]     rd_data1_s;
    logic                      accept_s;
    logic                      wb_live_s;

    logic                      out_valid_r;
    logic [2*DATA_WIDTH-1:0]   data_r;
    logic [CTRL_WIDTH-1:0]     ctrl_r;
    logic [SHAMT_WIDTH-1:0]    shamt_r;
    logic [REG_ADDR_WIDTH-1:0] dest_r;
    logic                      illegal_r;
    logic [REG_ADDR_WIDTH-1:0] src0_r;
    logic [REG_ADDR_WIDTH-1:0] src1_r;

    assign opcode_s      = instr[OPCODE_MSB:OPCODE_LSB];
    assign funct_s       = instr[FUNCT_MSB:FUNCT_LSB];
    assign rs_s          = instr[RS_MSB:RS_LSB];
    assign rt_s          = instr[RT_MSB:RT_LSB];
    assign rd_s          = instr[RD_MSB:RD_LSB];
    assign shamt_field_s = instr[SHAMT_MSB:SHAMT_LSB];
    assign class_s       = classify(opcode_s, funct_s);

    assign instrReady = !out_valid_r || outReady;
    assign accept_s   = instrValid && instrReady;
    assign wb_live_s  = wbEn && (wbAddr != {REG_ADDR_WIDTH{1'b0}});

    // Operand selection and field decode; shifts read rt into slot0 and r0 into slot1.
    always_comb begin
        src0_s         = rs_s;
        src1_s         = rt_s;
        shamt_next_s   = {SHAMT_WIDTH{1'b0}};
        dest_next_s    = rd_s;
        illegal_next_s = 1'b0;
        case (class_s)
            OP_SHIFT: begin
                src0_s       = rt_s;
                src1_s       = {REG_ADDR_WIDTH{1'b0}};
                shamt_next_s = shamt_field_s;
            end
            OP_ARITH: begin
                src0_s = rs_s;
                src1_s = rt_s;
            end
            OP_ILLEGAL: begin
                dest_next_s    = {REG_ADDR_WIDTH{1'b0}};
                illegal_next_s = 1'b1;
            end
            default: begin
                dest_next_s    = {REG_ADDR_WIDTH{1'b0}};
                illegal_next_s = 1'b1;
            end
        endcase
    end

    regfile_r0 #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wbEn),
        .wr_addr  (wbAddr),
        .wr_data  (wbData),
        .rd_addr0 (src0_s),
        .rd_addr1 (src1_s),
        .rd_data0 (rd_data0_s),
        .rd_data1 (rd_data1_s)
    );

    // Output holding register: load on accept, refresh operands while stalled, drain otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            data_r      <= {(2*DATA_WIDTH){1'b0}};
            ctrl_r      <= {CTRL_WIDTH{1'b0}};
            shamt_r     <= {SHAMT_WIDTH{1'b0}};
            dest_r      <= {REG_ADDR_WIDTH{1'b0}};
            illegal_r   <= 1'b0;
            src0_r      <= {REG_ADDR_WIDTH{1'b0}};
            src1_r      <= {REG_ADDR_WIDTH{1'b0}};
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            data_r      <= {rd_data1_s, rd_data0_s};
            ctrl_r      <= funct_s;
            shamt_r     <= shamt_next_s;
            dest_r      <= dest_next_s;
            illegal_r   <= illegal_next_s;
            src0_r      <= src0_s;
            src1_r      <= src1_s;
        end else if (out_valid_r && !outReady) begin
            if (wb_live_s && (wbAddr == src0_r)) begin
                data_r[DATA_WIDTH-1:0] <= wbData;
            end
            if (wb_live_s && (wbAddr == src1_r)) begin
                data_r[2*DATA_WIDTH-1:DATA_WIDTH] <= wbData;
            end
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign outValid = out_valid_r;
    assign dataOut  = data_r;
    assign ctrl     = ctrl_r;
    assign shamt    = shamt_r;
    assign destAddr = dest_r;
    assign illegal  = illegal_r;

endmodule

// File: tb/tb_id_stage_r0.sv
// Self-checking bench for id_stage_r0: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the stage.
module tb_id_stage_r0;

    logic        clk = 1'b0;
    logic        rst;
    logic        instrValid;
    logic [31:0] instr;
    logic        instrReady;
    logic        wbEn;
    logic [4:0]  wbAddr;
    logic [7:0]  wbData;
    logic        outValid;
    logic        outReady;
    logic [15:0] dataOut;
    logic [5:0]  ctrl;
    logic [4:0]  shamt;
    logic [4:0]  destAddr;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  m_regs [32];
    logic        m_valid;
    logic [15:0] m_data;
    logic [5:0]  m_ctrl;
    logic [4:0]  m_shamt;
    logic [4:0]  m_dest;
    logic        m_ill;
    int          m_src0;
    int          m_src1;

    always #5 clk = ~clk;

    id_stage_r0 dut (
        .clk        (clk),
        .rst        (rst),
        .instrValid (instrValid),
        .instr      (instr),
        .instrReady (instrReady),
        .wbEn       (wbEn),
        .wbAddr     (wbAddr),
        .wbData     (wbData),
        .outValid   (outValid),
        .outReady   (outReady),
        .dataOut    (dataOut),
        .ctrl       (ctrl),
        .shamt      (shamt),
        .destAddr   (destAddr),
        .illegal    (illegal)
    );

    function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh, input logic [5:0] fn);
        return {op, rs, rt, rd, sh, fn};
    endfunction

    // Architectural read as seen during the current cycle (r0 is zero, pending write visible).
    function automatic logic [7:0] m_read(input int idx);
        if (idx == 0) return 8'h00;
        if (wbEn && int'(wbAddr) == idx) return wbData;
        return m_regs[idx];
    endfunction

    task automatic model_edge();
        logic [5:0] op;
        logic [5:0] fn;
        bit         legal;
        bit         shift;
        bit         acc;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
            m_valid = 1'b0; m_data = 16'h0000; m_ctrl = 6'h00; m_shamt = 5'h00;
            m_dest = 5'h00; m_ill = 1'b0; m_src0 = -1; m_src1 = -1;
            return;
        end
        acc = instrValid && (!m_valid || outReady);
        if (acc) begin
            op    = instr[31:26];
            fn    = instr[5:0];
            legal = (op == 6'h00) && (fn inside {6'h00, 6'h02, 6'h03, 6'h20, 6'h22,
                                                 6'h24, 6'h25, 6'h26, 6'h27});
            shift = legal && (fn inside {6'h00, 6'h02, 6'h03});
            m_valid = 1'b1;
            m_ctrl  = fn;
            m_ill   = !legal;
            m_dest  = legal ? instr[15:11] : 5'h00;
            m_shamt = shift ? instr[10:6] : 5'h00;
            if (shift) begin
                m_src0 = int'(instr[20:16]);
                m_src1 = -1;
                m_data = {8'h00, m_read(m_src0)};
            end else if (legal) begin
                m_src0 = int'(instr[25:21]);
                m_src1 = int'(instr[20:16]);
                m_data = {m_read(m_src1), m_read(m_src0)};
            end else begin
                m_src0 = -1;
                m_src1 = -1;
                m_data = 16'h0000;
            end
        end else if (m_valid && !outReady) begin
            if (wbEn && wbAddr != 5'd0 && int'(wbAddr) == m_src0) m_data[7:0]  = wbData;
            if (wbEn && wbAddr != 5'd0 && int'(wbAddr) == m_src1) m_data[15:8] = wbData;
        end else begin
            m_valid = 1'b0;
        end
        if (wbEn && wbAddr != 5'd0) m_regs[wbAddr] = wbData;
    endtask

    task automatic apply(input logic iv, input logic [31:0] ins, input logic we,
                         input logic [4:0] wa, input logic [7:0] wd, input logic ordy);
        instrValid = iv; instr = ins; wbEn = we; wbAddr = wa; wbData = wd; outReady = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(1'b0, 32'h0, 1'b0, 5'd0, 8'h00, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        apply(1'b0, 32'h0, 1'b0, 5'd0, 8'h00, 1'b0);
        checks++;
        if ({outValid, dataOut, ctrl, shamt, destAddr, illegal} !== 30'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {outValid, dataOut, ctrl, shamt, destAddr, illegal});
        end
        checks++;
        if (instrReady !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", instrReady);
        end
    endtask

    task automatic test_basic();
        apply(1'b0, 32'h0, 1'b1, 5'd3, 8'h15, 1'b1); tick();
        apply(1'b0, 32'h0, 1'b1, 5'd4, 8'h07, 1'b1); tick();
        apply(1'b1, 32'h00642820, 1'b0, 5'd0, 8'h00, 1'b1); tick();
        checks++;
        if ({outValid, dataOut, ctrl, destAddr, illegal, shamt} !== {1'b1, 16'h0715, 6'h20, 5'd5, 1'b0, 5'd0}) begin
            failures++;
            $display("FAIL add got v=%b d=%h c=%h rd=%0d il=%b sh=%0d exp v=1 d=0715 c=20 rd=5 il=0 sh=0",
                     outValid, dataOut, ctrl, destAddr, illegal, shamt);
        end
        apply(1'b1, 32'h000410C0, 1'b0, 5'd0, 8'h00, 1'b1); tick();
        checks++;
        if ({outValid, dataOut, ctrl, destAddr, shamt} !== {1'b1, 16'h0007, 6'h00, 5'd2, 5'd3}) begin
            failures++;
            $display("FAIL sll got v=%b d=%h c=%h rd=%0d sh=%0d exp v=1 d=0007 c=00 rd=2 sh=3",
                     outValid, dataOut, ctrl, destAddr, shamt);
        end
    endtask

    task automatic test_bypass();
        apply(1'b1, 32'h00643022, 1'b1, 5'd3, 8'hAA, 1'b1); tick();
        checks++;
        if ({outValid, dataOut, ctrl, destAddr} !== {1'b1, 16'h07AA, 6'h22, 5'd6}) begin
            failures++;
            $display("FAIL bypass got v=%b d=%h c=%h rd=%0d exp v=1 d=07aa c=22 rd=6",
                     outValid, dataOut, ctrl, destAddr);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 32'h00A62020, (i == 1), 5'd4, 8'h55, 1'b0);
            checks++;
            if (instrReady !== 1'b0) begin
                failures++;
                $display("FAIL stall_ready cycle %0d got=%b exp=0", i, instrReady);
            end
            tick();
            checks++;
            if ({outValid, ctrl, destAddr, illegal, shamt} !== {1'b1, 6'h22, 5'd6, 1'b0, 5'd0}) begin
                failures++;
                $display("FAIL stall_hold cycle %0d got v=%b c=%h rd=%0d il=%b sh=%0d exp v=1 c=22 rd=6 il=0 sh=0",
                         i, outValid, ctrl, destAddr, illegal, shamt);
            end
            checks++;
            if (dataOut !== ((i == 0) ? 16'h07AA : 16'h55AA)) begin
                failures++;
                $display("FAIL stall_refresh cycle %0d got=%h exp=%h", i, dataOut, (i == 0) ? 16'h07AA : 16'h55AA);
            end
        end
        apply(1'b0, 32'h0, 1'b0, 5'd0, 8'h00, 1'b1);
        checks++;
        if (instrReady !== 1'b1) begin
            failures++;
            $display("FAIL drain_ready got=%b exp=1", instrReady);
        end
        tick();
        checks++;
        if (outValid !== 1'b0) begin
            failures++;
            $display("FAIL drain_valid got=%b exp=0", outValid);
        end
    endtask

    task automatic test_r0_illegal();
        apply(1'b0, 32'h0, 1'b1, 5'd0, 8'hFF, 1'b1); tick();
        apply(1'b1, rtype(6'h00, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20), 1'b1, 5'd0, 8'hFF, 1'b1); tick();
        checks++;
        if ({outValid, dataOut, destAddr, illegal} !== {1'b1, 16'h0000, 5'd1, 1'b0}) begin
            failures++;
            $display("FAIL r0_read got v=%b d=%h rd=%0d il=%b exp v=1 d=0000 rd=1 il=0",
                     outValid, dataOut, destAddr, illegal);
        end
        apply(1'b1, rtype(6'h08, 5'd3, 5'd4, 5'd5, 5'd7, 6'h20), 1'b0, 5'd0, 8'h00, 1'b1); tick();
        checks++;
        if ({outValid, illegal, destAddr, ctrl, shamt} !== {1'b1, 1'b1, 5'd0, 6'h20, 5'd0}) begin
            failures++;
            $display("FAIL illegal_opcode got v=%b il=%b rd=%0d c=%h sh=%0d exp v=1 il=1 rd=0 c=20 sh=0",
                     outValid, illegal, destAddr, ctrl, shamt);
        end
        apply(1'b1, rtype(6'h00, 5'd3, 5'd4, 5'd5, 5'd2, 6'h01), 1'b0, 5'd0, 8'h00, 1'b1); tick();
        checks++;
        if ({outValid, illegal, destAddr, ctrl, shamt} !== {1'b1, 1'b1, 5'd0, 6'h01, 5'd0}) begin
            failures++;
            $display("FAIL illegal_funct got v=%b il=%b rd=%0d c=%h sh=%0d exp v=1 il=1 rd=0 c=01 sh=0",
                     outValid, illegal, destAddr, ctrl, shamt);
        end
    endtask

    task automatic test_random();
        logic [5:0]  legal_tab [9];
        logic [31:0] ins;
        int          sel;
        legal_tab = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 9);
            ins = rtype(6'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        5'($urandom), 5'($urandom), legal_tab[$urandom_range(0, 8)]);
            if (sel == 7) ins[31:26] = 6'($urandom_range(1, 63));
            if (sel >= 8) ins[5:0] = 6'($urandom);
            apply(($urandom_range(0, 9) < 7), ins, ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 7)), 8'($urandom), ($urandom_range(0, 9) < 6));
            checks++;
            if (instrReady !== (!m_valid || outReady)) begin
                failures++;
                $display("FAIL rand_ready n=%0d got=%b exp=%b", n, instrReady, !m_valid || outReady);
            end
            tick();
            checks++;
            if (outValid !== m_valid) begin
                failures++;
                $display("FAIL rand_valid n=%0d got=%b exp=%b", n, outValid, m_valid);
            end
            if (m_valid) begin
                checks++;
                if ({ctrl, shamt, destAddr, illegal} !== {m_ctrl, m_shamt, m_dest, m_ill}) begin
                    failures++;
                    $display("FAIL rand_ctrl n=%0d got c=%h sh=%0d rd=%0d il=%b exp c=%h sh=%0d rd=%0d il=%b",
                             n, ctrl, shamt, destAddr, illegal, m_ctrl, m_shamt, m_dest, m_ill);
                end
                if (!m_ill) begin
                    checks++;
                    if (dataOut !== m_data) begin
                        failures++;
                        $display("FAIL rand_data n=%0d got=%h exp=%h", n, dataOut, m_data);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        apply(1'b1, 32'h00642820, 1'b1, 5'd3, 8'h3C, 1'b1); tick();
        apply(1'b0, 32'h0, 1'b0, 5'd0, 8'h00, 1'b0); tick();
        checks++;
        if (outValid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_valid got=%b exp=1", outValid);
        end
        rst = 1'b1;
        apply(1'b0, 32'h0, 1'b0, 5'd0, 8'h00, 1'b0); tick();
        rst = 1'b0;
        apply(1'b0, 32'h0, 1'b0, 5'd0, 8'h00, 1'b0);
        checks++;
        if ({outValid, dataOut, ctrl, shamt, destAddr, illegal} !== 30'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%h exp=0", {outValid, dataOut, ctrl, shamt, destAddr, illegal});
        end
        apply(1'b1, 32'h00642820, 1'b0, 5'd0, 8'h00, 1'b1); tick();
        checks++;
        if ({outValid, dataOut} !== {1'b1, 16'h0000}) begin
            failures++;
            $display("FAIL mid_reset_regs got v=%b d=%h exp v=1 d=0000", outValid, dataOut);
        end
    endtask

    initial begin
        rst = 1'b1;
        apply(1'b0, 32'h0, 1'b0, 5'd0, 8'h00, 1'b0);
        test_reset();
        test_basic();
        test_bypass();
        test_stall();
        test_r0_illegal();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
